diff_window_accum: RTL and testbench

Downstream consumer of the registered 5-bit subtractor result (ui_in[3:0] - ui_in[7:4]).
- Accumulates a window of WINDOW signed difference samples into a saturating ACC_W-bit signed sum.
- Presents the sum with a valid/ready handshake to the output mux / uo_out driver.
- Gives the tapeout design a "sum of differences over N samples" measurement instead of a single-shot result.

---
 rtl/diff_accum_pkg.sv | 21 ++
 rtl/sat_add.sv | 36 +++
 rtl/diff_window_accum.sv | 100 ++++++++++
 tb/tb_diff_window_accum.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/diff_accum_pkg.sv
// Shared types and constants for the windowed difference accumulator.
// Holds the FSM encoding, the sample width and the signed rail helpers.
package diff_accum_pkg;

  localparam int DIFF_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int acc_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add of a signed DIFF_W-bit sample into a signed ACC_W-bit sum.
// ovf flags that the true sum fell outside the ACC_W range and was clamped to a rail.
module sat_add
  import diff_accum_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DIFF_W-1:0] sample,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int MAX_I = acc_max(ACC_W);
  localparam int MIN_I = acc_min(ACC_W);
  localparam logic signed [ACC_W:0] MAX_W = MAX_I[ACC_W:0];
  localparam logic signed [ACC_W:0] MIN_W = MIN_I[ACC_W:0];

  logic signed [ACC_W:0] wide;

  // One guard bit is enough: |sample| is far below the accumulator range.
  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DIFF_W){sample[DIFF_W-1]}}, sample};

  always_comb begin
    sum = wide[ACC_W-1:0];
    ovf = 1'b0;
    if (wide > MAX_W) begin
      sum = MAX_W[ACC_W-1:0];
      ovf = 1'b1;
    end else if (wide < MIN_W) begin
      sum = MIN_W[ACC_W-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/diff_window_accum.sv
// Sums WINDOW accepted difference samples into a saturating signed result and
// offers it with valid/ready; the result is held in HOLD until out_ready is seen.
module diff_window_accum
  import diff_accum_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int ACC_W  = 10,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DIFF_W-1:0] diff_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    win_sat;
  logic                    xfer;
  logic                    last;
  logic                    clr;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc    (acc),
    .sample (diff_in),
    .sum    (sum),
    .ovf    (ovf)
  );

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  assign xfer = in_valid & in_ready;
  assign last = (count == LAST_CNT);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          clr       = 1'b1;
        end
      end
      ACCUM: begin
        if (xfer && last) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = start ? ACCUM : IDLE;
          clr       = start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      acc_out <= '0;
      count   <= '0;
      win_sat <= 1'b0;
      sat     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        acc     <= '0;
        count   <= '0;
        win_sat <= 1'b0;
      end else if (xfer) begin
        acc     <= sum;
        count   <= count + CNT_W'(1);
        win_sat <= win_sat | ovf;
        // Result registers only change on the closing transfer of a window.
        if (last) begin
          acc_out <= sum;
          sat     <= win_sat | ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_diff_window_accum.sv
// Directed checks of diff_window_accum across four parameter sets sharing one clock and reset.
module tb_diff_window_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] start, in_valid, out_ready;
  logic [4:0] d0, d1, d2, d3;

  logic              ir0, ir1, ir2, ir3;
  logic              ov0, ov1, ov2, ov3;
  logic              sat0, sat1, sat2, sat3;
  logic              bz0, bz1, bz2, bz3;
  logic [7:0]        c0, c1, c2, c3;
  logic signed [9:0] acc0, acc1, acc3;
  logic signed [5:0] acc2;

  int tests = 0;
  int fails = 0;

  logic [4:0] samp [4] = '{5'b01111, 5'b10001, 5'b11111, 5'b00010};
  int         gaps [4] = '{0, 1, 2, 3};

  diff_window_accum #(.WINDOW(8), .ACC_W(10), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .diff_in(d0), .in_valid(in_valid[0]),
    .in_ready(ir0), .acc_out(acc0), .out_valid(ov0), .out_ready(out_ready[0]),
    .sat(sat0), .busy(bz0), .count(c0));

  diff_window_accum #(.WINDOW(4), .ACC_W(10), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .diff_in(d1), .in_valid(in_valid[1]),
    .in_ready(ir1), .acc_out(acc1), .out_valid(ov1), .out_ready(out_ready[1]),
    .sat(sat1), .busy(bz1), .count(c1));

  diff_window_accum #(.WINDOW(8), .ACC_W(6), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .diff_in(d2), .in_valid(in_valid[2]),
    .in_ready(ir2), .acc_out(acc2), .out_valid(ov2), .out_ready(out_ready[2]),
    .sat(sat2), .busy(bz2), .count(c2));

  diff_window_accum #(.WINDOW(1), .ACC_W(10), .CNT_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .diff_in(d3), .in_valid(in_valid[3]),
    .in_ready(ir3), .acc_out(acc3), .out_valid(ov3), .out_ready(out_ready[3]),
    .sat(sat3), .busy(bz3), .count(c3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0; in_valid = '0; out_ready = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    tick; tick;
    chk("rst_out_valid", ov0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_in_ready", ir0, 0);
    chk("rst_count", c0, 0);
    chk("rst_acc_out", acc0, 0);
    chk("rst_sat", sat0, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_in_ready", ir0, 0);

    // Eight transfers of +3 with default parameters.
    start[0] = 1'b1; tick; start[0] = 1'b0;
    chk("t1_in_ready", ir0, 1);
    chk("t1_busy", bz0, 1);
    chk("t1_count0", c0, 0);
    for (int i = 0; i < 7; i++) begin
      d0 = 5'b00011; in_valid[0] = 1'b1; tick;
    end
    chk("t1_ov_before_last", ov0, 0);
    chk("t1_count7", c0, 7);
    tick;
    chk("t1_out_valid", ov0, 1);
    chk("t1_acc_out", acc0, 24);
    chk("t1_sat", sat0, 0);
    chk("t1_count8", c0, 8);
    chk("t1_hold_in_ready", ir0, 0);

    // Backpressure in HOLD: start and in_valid must both be ignored.
    start[0] = 1'b1; d0 = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_out_valid", ov0, 1);
      chk("bp_acc_out", acc0, 24);
      chk("bp_count", c0, 8);
      chk("bp_in_ready", ir0, 0);
    end
    out_ready[0] = 1'b1; tick;
    out_ready[0] = 1'b0; start[0] = 1'b0; in_valid[0] = 1'b0;
    chk("b2b_out_valid", ov0, 0);
    chk("b2b_in_ready", ir0, 1);
    chk("b2b_count", c0, 0);
    chk("b2b_acc_retained", acc0, 24);

    // Reset mid-window discards partial samples.
    for (int i = 0; i < 3; i++) begin
      d0 = 5'b00101; in_valid[0] = 1'b1; tick;
    end
    in_valid[0] = 1'b0;
    chk("mid_count3", c0, 3);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    chk("mid_rst_busy", bz0, 0);
    chk("mid_rst_in_ready", ir0, 0);
    chk("mid_rst_count", c0, 0);
    chk("mid_rst_acc_out", acc0, 0);
    chk("mid_rst_out_valid", ov0, 0);
    start[0] = 1'b1; tick; start[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d0 = 5'b11110; in_valid[0] = 1'b1; tick;
    end
    in_valid[0] = 1'b0;
    chk("mid_out_valid", ov0, 1);
    chk("mid_acc_out", acc0, -16);
    chk("mid_sat", sat0, 0);
    out_ready[0] = 1'b1; tick; out_ready[0] = 1'b0;
    chk("idle_out_valid", ov0, 0);
    chk("idle_busy", bz0, 0);
    chk("idle_count_held", c0, 8);
    chk("idle_acc_retained", acc0, -16);

    // WINDOW=4 with in_valid gaps.
    start[1] = 1'b1; tick; start[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        in_valid[1] = 1'b0; tick;
      end
      chk("t2_count_gap", c1, k);
      chk("t2_ov_pending", ov1, 0);
      d1 = samp[k]; in_valid[1] = 1'b1; tick; in_valid[1] = 1'b0;
    end
    chk("t2_out_valid", ov1, 1);
    chk("t2_acc_out", acc1, 1);
    chk("t2_count", c1, 4);
    chk("t2_sat", sat1, 0);
    out_ready[1] = 1'b1; tick; out_ready[1] = 1'b0;
    chk("t2_idle", bz1, 0);

    // ACC_W=6 saturation, both rails, then sticky flag cleared.
    start[2] = 1'b1; tick; start[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d2 = 5'b01111; in_valid[2] = 1'b1; tick;
    end
    in_valid[2] = 1'b0;
    chk("t3_pos_ov", ov2, 1);
    chk("t3_pos_acc", acc2, 31);
    chk("t3_pos_sat", sat2, 1);
    out_ready[2] = 1'b1; start[2] = 1'b1; tick; out_ready[2] = 1'b0; start[2] = 1'b0;
    chk("t3_b2b_count", c2, 0);
    chk("t3_b2b_ov", ov2, 0);
    for (int i = 0; i < 8; i++) begin
      d2 = 5'b10001; in_valid[2] = 1'b1; tick;
    end
    in_valid[2] = 1'b0;
    chk("t3_neg_acc", acc2, -32);
    chk("t3_neg_sat", sat2, 1);
    out_ready[2] = 1'b1; start[2] = 1'b1; tick; out_ready[2] = 1'b0; start[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d2 = 5'b00001; in_valid[2] = 1'b1; tick;
    end
    in_valid[2] = 1'b0;
    chk("t3_small_acc", acc2, 8);
    chk("t3_small_sat", sat2, 0);
    chk("t3_small_ov", ov2, 1);

    // WINDOW=1: a single transfer completes the window.
    start[3] = 1'b1; tick; start[3] = 1'b0;
    d3 = 5'b11001; in_valid[3] = 1'b1; tick; in_valid[3] = 1'b0;
    chk("t4_out_valid", ov3, 1);
    chk("t4_acc_out", acc3, -7);
    chk("t4_count", c3, 1);
    chk("t4_in_ready", ir3, 0);
    out_ready[3] = 1'b1; tick; out_ready[3] = 1'b0;
    chk("t4_idle_busy", bz3, 0);
    chk("t4_idle_ov", ov3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
